// File: rtl/axi_lite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_pkg                                                         |
// | Shared response encodings and channel state types for the AXI4-Lite |
// | memory responder.                                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package axi_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_mem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_mem_ram                                                     |
// | DEPTH x DATA_WIDTH RAM, one byte-enabled write port and one          |
// | synchronous read port; a same-edge collision returns the old word.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axi_lite_mem_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256
) (
   input  logic                          clk_i,
   input  logic                          we_i,
   input  logic [$clog2(DEPTH)-1:0]      waddr_i,
   input  logic [DATA_WIDTH-1:0]         wdata_i,
   input  logic [DATA_WIDTH/8-1:0]       wstrb_i,
   input  logic                          re_i,
   input  logic [$clog2(DEPTH)-1:0]      raddr_i,
   output logic [DATA_WIDTH-1:0]         rdata_o
);

   localparam int STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Read and write share one block so the read samples the pre-write word.
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
      if (we_i) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_i[b]) begin
               mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_mem_slave                                                   |
// | AXI4-Lite responder backed by on-chip RAM, independent AW/W/B and    |
// | AR/R state machines. Define AXI_SLV_RANGE_CHECK_EN to answer         |
// | out-of-range accesses with SLVERR instead of aliasing.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axi_lite_mem_slave
   import axi_lite_pkg::*;
#(
   parameter int                         AXI_ADDR_WIDTH = 64,
   parameter int                         AXI_DATA_WIDTH = 32,
   parameter int                         MEM_DEPTH      = 256,
   parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = '0
) (
   input  logic                          clk_i,
   input  logic                          arst_i,
   input  logic [AXI_ADDR_WIDTH-1:0]     awaddr_i,
   input  logic                          awvalid_i,
   output logic                          awready_o,
   input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
   input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_i,
   input  logic                          wvalid_i,
   output logic                          wready_o,
   output logic [1:0]                    bresp_o,
   output logic                          bvalid_o,
   input  logic                          bready_i,
   input  logic [AXI_ADDR_WIDTH-1:0]     araddr_i,
   input  logic                          arvalid_i,
   output logic                          arready_o,
   output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
   output logic [1:0]                    rresp_o,
   output logic                          rvalid_o,
   input  logic                          rready_i
);

   localparam int STRB_W   = AXI_DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = $clog2(MEM_DEPTH);
   localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_DEPTH * STRB_W);

   wr_state_t                   wr_state_q, wr_state_d;
   logic                        aw_held_q, aw_held_d;
   logic                        w_held_q, w_held_d;
   logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]           wstrb_q, wstrb_d;
   resp_t                       bresp_q, bresp_d;

   rd_state_t                   rd_state_q, rd_state_d;
   resp_t                       rresp_q, rresp_d;
   logic                        rd_ok_q, rd_ok_d;

   logic                        aw_hs, w_hs, ar_hs, ram_we;
   logic [AXI_ADDR_WIDTH-1:0]   wr_addr, wr_off, rd_off;
   logic [AXI_DATA_WIDTH-1:0]   wr_data, ram_rdata;
   logic [STRB_W-1:0]           wr_strb;
   logic                        wr_in_range, rd_in_range;
   logic                        unused_off_bits;

   assign awready_o = (wr_state_q == W_IDLE) && !aw_held_q && !arst_i;
   assign wready_o  = (wr_state_q == W_IDLE) && !w_held_q && !arst_i;
   assign arready_o = (rd_state_q == R_IDLE) && !arst_i;
   assign aw_hs     = awvalid_i && awready_o;
   assign w_hs      = wvalid_i && wready_o;
   assign ar_hs     = arvalid_i && arready_o;

   // Held copies win over the live bus once a channel has already handshaken.
   assign wr_addr = aw_held_q ? awaddr_q : awaddr_i;
   assign wr_data = w_held_q  ? wdata_q  : wdata_i;
   assign wr_strb = w_held_q  ? wstrb_q  : wstrb_i;
   assign wr_off  = wr_addr - BASE_ADDR;
   assign rd_off  = araddr_i - BASE_ADDR;
   assign unused_off_bits = ^{wr_off, rd_off};

`ifdef AXI_SLV_RANGE_CHECK_EN
   assign wr_in_range = (wr_off < MEM_BYTES);
   assign rd_in_range = (rd_off < MEM_BYTES);
`else
   assign wr_in_range = 1'b1;
   assign rd_in_range = 1'b1;
`endif

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      ram_we     = 1'b0;
      if (wr_state_q == W_IDLE) begin
         if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr_i;
         end
         if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = wdata_i;
            wstrb_d  = wstrb_i;
         end
         if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
            ram_we     = wr_in_range;
            bresp_d    = wr_in_range ? OKAY : SLVERR;
            wr_state_d = W_RESP;
         end
      end else if (bready_i) begin
         wr_state_d = W_IDLE;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rresp_d    = rresp_q;
      rd_ok_d    = rd_ok_q;
      if (rd_state_q == R_IDLE) begin
         if (ar_hs) begin
            rd_state_d = R_DATA;
            rresp_d    = rd_in_range ? OKAY : SLVERR;
            rd_ok_d    = rd_in_range;
         end
      end else if (rready_i) begin
         rd_state_d = R_IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         wr_state_q <= W_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= OKAY;
         rd_state_q <= R_IDLE;
         rresp_q    <= OKAY;
         rd_ok_q    <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         rd_state_q <= rd_state_d;
         rresp_q    <= rresp_d;
         rd_ok_q    <= rd_ok_d;
      end
   end

   axi_lite_mem_ram #(
      .DATA_WIDTH (AXI_DATA_WIDTH),
      .DEPTH      (MEM_DEPTH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (wr_off[ADDR_LSB +: IDX_W]),
      .wdata_i (wr_data),
      .wstrb_i (wr_strb),
      .re_i    (ar_hs),
      .raddr_i (rd_off[ADDR_LSB +: IDX_W]),
      .rdata_o (ram_rdata)
   );

   // RAM output is not reset, so it is masked until a valid in-range read lands.
   assign rdata_o  = rd_ok_q ? ram_rdata : '0;
   assign rresp_o  = rresp_q;
   assign rvalid_o = (rd_state_q == R_DATA);
   assign bresp_o  = bresp_q;
   assign bvalid_o = (wr_state_q == W_RESP);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_mem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_lite_mem_slave                                                |
// | Randomised self-checking bench with a word-array reference model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_axi_lite_mem_slave;

   localparam logic [63:0] BASE = 64'h0;
   localparam int          DEPTH = 256;
   localparam logic [1:0]  R_OK  = 2'b00;
   localparam logic [1:0]  R_ERR = 2'b10;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic [63:0] awaddr = '0, araddr = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   int errors = 0;
   int checks = 0;
   logic [31:0] mem_m [DEPTH];

   always #5 clk = ~clk;

   axi_lite_mem_slave dut (
      .clk_i     (clk),
      .arst_i    (arst),
      .awaddr_i  (awaddr),
      .awvalid_i (awvalid),
      .awready_o (awready),
      .wdata_i   (wdata),
      .wstrb_i   (wstrb),
      .wvalid_i  (wvalid),
      .wready_o  (wready),
      .bresp_o   (bresp),
      .bvalid_o  (bvalid),
      .bready_i  (bready),
      .araddr_i  (araddr),
      .arvalid_i (arvalid),
      .arready_o (arready),
      .rdata_o   (rdata),
      .rresp_o   (rresp),
      .rvalid_o  (rvalid),
      .rready_i  (rready)
   );

   // Reference model: byte offset from the base, word = offset/4 modulo depth.
   function automatic bit m_in_range(input logic [63:0] a);
`ifdef AXI_SLV_RANGE_CHECK_EN
      return (a - BASE) < 64'(DEPTH * 4);
`else
      return 1'b1;
`endif
   endfunction

   function automatic int m_idx(input logic [63:0] a);
      logic [63:0] off;
      off = a - BASE;
      return int'((off / 64'd4) % 64'(DEPTH));
   endfunction

   function automatic void m_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
      if (m_in_range(a)) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) mem_m[m_idx(a)][8*b +: 8] = d[8*b +: 8];
         end
      end
   endfunction

   function automatic logic [31:0] m_read(input logic [63:0] a);
      return m_in_range(a) ? mem_m[m_idx(a)] : 32'h0;
   endfunction

   function automatic logic [1:0] m_resp(input logic [63:0] a);
      return m_in_range(a) ? R_OK : R_ERR;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_write(input logic [63:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output bit ontime, output bit tmo);
      bit aw_done, w_done, aw_fire, w_fire;
      int c;
      aw_done = 0; w_done = 0; c = 0; tmo = 0;
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done)) begin
         if (c > 40) begin tmo = 1; break; end
         awvalid = !aw_done && (c >= aw_dly);
         wvalid  = !w_done && (c >= w_dly);
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         step(); c++;
         if (aw_fire) aw_done = 1;
         if (w_fire) w_done = 1;
      end
      awvalid = 0; wvalid = 0;
      ontime = (bvalid === 1'b1);
      repeat (b_dly) step();
      bready = 1; c = 0;
      while (bvalid !== 1'b1 && c < 40) begin step(); c++; end
      if (bvalid !== 1'b1) tmo = 1;
      resp = bresp;
      step();
      bready = 0;
   endtask

   task automatic drv_read(input logic [63:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp,
                           output bit ontime, output bit tmo);
      int c;
      c = 0; tmo = 0;
      araddr = addr; arvalid = 1;
      while (arready !== 1'b1 && c < 40) begin step(); c++; end
      if (arready !== 1'b1) tmo = 1;
      step();
      arvalid = 0;
      ontime = (rvalid === 1'b1);
      repeat (r_dly) step();
      rready = 1; c = 0;
      while (rvalid !== 1'b1 && c < 40) begin step(); c++; end
      if (rvalid !== 1'b1) tmo = 1;
      data = rdata; resp = rresp;
      step();
      rready = 0;
   endtask

   task automatic test_reset();
      arst = 1;
      repeat (3) step();
      checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL reset_readys got=%b want=000", {awready, wready, arready}); end
      checks++; if ({bvalid, rvalid} !== 2'b00) begin errors++; $display("FAIL reset_valids got=%b want=00", {bvalid, rvalid}); end
      checks++; if ({bresp, rresp, rdata} !== 36'h0) begin errors++; $display("FAIL reset_outputs bresp=%b rresp=%b rdata=%h want 0", bresp, rresp, rdata); end
      arst = 0;
      step();
      checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL reset_release_readys got=%b want=111", {awready, wready, arready}); end
   endtask

   task automatic test_same_cycle();
      logic [1:0] resp; logic [31:0] d; bit ot, tmo;
      drv_write(64'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, ot, tmo);
      m_write(64'h8, 32'hDEADBEEF, 4'hF);
      checks++; if ({tmo, ot, resp} !== {1'b0, 1'b1, R_OK}) begin errors++; $display("FAIL same_cycle_b tmo=%0d ontime=%0d resp=%b want 0/1/00", tmo, ot, resp); end
      drv_read(64'h8, 0, d, resp, ot, tmo);
      checks++; if ({tmo, ot, resp} !== {1'b0, 1'b1, R_OK}) begin errors++; $display("FAIL same_cycle_r tmo=%0d ontime=%0d resp=%b want 0/1/00", tmo, ot, resp); end
      checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL same_cycle_rdata got=%h want=deadbeef", d); end
   endtask

   task automatic test_w_before_aw();
      logic [1:0] resp; logic [31:0] d; bit ot, tmo;
      wdata = 32'h11223344; wstrb = 4'h3; wvalid = 1;
      step();
      wvalid = 0;
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL w_first_wready got=%b want=0", wready); end
      step();
      checks++; if ({wready, bvalid} !== 2'b00) begin errors++; $display("FAIL w_first_wait wready/bvalid got=%b want=00", {wready, bvalid}); end
      awaddr = 64'h8; awvalid = 1;
      step();
      awvalid = 0;
      m_write(64'h8, 32'h11223344, 4'h3);
      checks++; if ({bvalid, bresp} !== {1'b1, R_OK}) begin errors++; $display("FAIL w_first_b bvalid/bresp got=%b want=100", {bvalid, bresp}); end
      bready = 1; step(); bready = 0;
      drv_read(64'h8, 1, d, resp, ot, tmo);
      checks++; if ({tmo, resp, d} !== {1'b0, R_OK, 32'hDEAD3344}) begin errors++; $display("FAIL w_first_rdata got=%h resp=%b tmo=%0d want=dead3344", d, resp, tmo); end
   endtask

   task automatic test_burst_backpressure();
      logic [1:0] resp; logic [31:0] d, v; bit ot, tmo;
      v = $urandom;
      awaddr = 64'h0; wdata = v; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      step();
      awvalid = 0; wvalid = 0;
      m_write(64'h0, v, 4'hF);
      for (int i = 0; i < 3; i++) begin
         checks++; if ({bvalid, awready, wready} !== 3'b100) begin errors++; $display("FAIL burst_stall%0d bvalid/awready/wready got=%b want=100", i, {bvalid, awready, wready}); end
         step();
      end
      bready = 1; step(); bready = 0;
      checks++; if ({bvalid, awready, wready} !== 3'b011) begin errors++; $display("FAIL burst_release got=%b want=011", {bvalid, awready, wready}); end
      for (int i = 1; i < 4; i++) begin
         v = $urandom;
         drv_write(64'(4 * i), v, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0, resp, ot, tmo);
         m_write(64'(4 * i), v, 4'hF);
         checks++; if ({tmo, ot, resp} !== {1'b0, 1'b1, R_OK}) begin errors++; $display("FAIL burst_b%0d tmo=%0d ontime=%0d resp=%b", i, tmo, ot, resp); end
      end
      for (int i = 0; i < 4; i++) begin
         drv_read(64'(4 * i), 0, d, resp, ot, tmo);
         checks++; if ({tmo, d} !== {1'b0, m_read(64'(4 * i))}) begin errors++; $display("FAIL burst_read%0d got=%h want=%h tmo=%0d", i, d, m_read(64'(4 * i)), tmo); end
      end
   endtask

   task automatic test_collision();
      logic [1:0] resp; logic [31:0] d; bit ot, tmo;
      drv_write(64'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 0, resp, ot, tmo);
      m_write(64'h10, 32'hA5A5A5A5, 4'hF);
      araddr = 64'h10; arvalid = 1;
      awaddr = 64'h10; awvalid = 1; wdata = 32'h0; wstrb = 4'hF; wvalid = 1;
      step();
      arvalid = 0; awvalid = 0; wvalid = 0;
      checks++; if ({rvalid, bvalid, rdata} !== {2'b11, 32'hA5A5A5A5}) begin errors++; $display("FAIL collision_old rvalid/bvalid=%b rdata=%h want 11/a5a5a5a5", {rvalid, bvalid}, rdata); end
      m_write(64'h10, 32'h0, 4'hF);
      bready = 1; rready = 1; step(); bready = 0; rready = 0;
      drv_read(64'h10, 0, d, resp, ot, tmo);
      checks++; if ({tmo, d} !== {1'b0, 32'h0}) begin errors++; $display("FAIL collision_new got=%h want=00000000 tmo=%0d", d, tmo); end
   endtask

   task automatic test_range();
      logic [1:0] resp; logic [31:0] d, v; bit ot, tmo;
      v = $urandom;
      drv_write(64'h400, v, 4'hF, 0, 0, 0, resp, ot, tmo);
      checks++; if ({tmo, resp} !== {1'b0, m_resp(64'h400)}) begin errors++; $display("FAIL range_bresp got=%b want=%b tmo=%0d", resp, m_resp(64'h400), tmo); end
      m_write(64'h400, v, 4'hF);
      drv_read(64'h400, 0, d, resp, ot, tmo);
      checks++; if ({tmo, resp, d} !== {1'b0, m_resp(64'h400), m_read(64'h400)}) begin errors++; $display("FAIL range_read got=%h/%b want=%h/%b", d, resp, m_read(64'h400), m_resp(64'h400)); end
      drv_read(64'h0, 0, d, resp, ot, tmo);
      checks++; if ({tmo, d} !== {1'b0, m_read(64'h0)}) begin errors++; $display("FAIL range_word0 got=%h want=%h", d, m_read(64'h0)); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp; logic [31:0] d, v; bit ot, tmo;
      v = $urandom;
      awaddr = 64'h20; wdata = v; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      step();
      awvalid = 0; wvalid = 0;
      m_write(64'h20, v, 4'hF);
      checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre bvalid got=%b want=1", bvalid); end
      arst = 1;
      step();
      checks++; if ({bvalid, awready, wready, arready} !== 4'b0000) begin errors++; $display("FAIL rst_mid_drop got=%b want=0000", {bvalid, awready, wready, arready}); end
      arst = 0;
      step();
      checks++; if ({bvalid, awready, wready, arready} !== 4'b0111) begin errors++; $display("FAIL rst_mid_release got=%b want=0111", {bvalid, awready, wready, arready}); end
      awaddr = 64'h24; awvalid = 1;
      step();
      awvalid = 0;
      arst = 1; step(); arst = 0; step();
      v = $urandom;
      wdata = v; wstrb = 4'hF; wvalid = 1;
      step();
      wvalid = 0;
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rst_half_aw bvalid got=%b want=0", bvalid); end
      awaddr = 64'h28; awvalid = 1;
      step();
      awvalid = 0;
      m_write(64'h28, v, 4'hF);
      checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL rst_half_complete bvalid got=%b want=1", bvalid); end
      bready = 1; step(); bready = 0;
      drv_read(64'h28, 0, d, resp, ot, tmo);
      checks++; if ({tmo, d} !== {1'b0, v}) begin errors++; $display("FAIL rst_half_read got=%h want=%h", d, v); end
   endtask

   task automatic test_random();
      logic [1:0] resp; logic [31:0] d, v; logic [63:0] a; logic [3:0] s; bit ot, tmo;
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom;
         drv_write(64'(4 * i), v, 4'hF, 0, 0, 0, resp, ot, tmo);
         m_write(64'(4 * i), v, 4'hF);
         checks++; if ({tmo, resp} !== {1'b0, R_OK}) begin errors++; $display("FAIL fill%0d resp=%b tmo=%0d", i, resp, tmo); end
      end
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 7))
            0:       a = {$urandom, $urandom};
            1:       a = 64'h400 + 64'($urandom_range(0, 4095));
            default: a = 64'($urandom_range(0, DEPTH * 4 - 1));
         endcase
         if ($urandom_range(0, 1) == 1) begin
            v = $urandom; s = 4'($urandom_range(0, 15));
            drv_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, ot, tmo);
            checks++; if ({tmo, ot, resp} !== {1'b0, 1'b1, m_resp(a)}) begin errors++; $display("FAIL rnd_write%0d a=%h tmo=%0d ontime=%0d resp=%b want=%b", i, a, tmo, ot, resp, m_resp(a)); end
            m_write(a, v, s);
         end else begin
            drv_read(a, $urandom_range(0, 2), d, resp, ot, tmo);
            checks++; if ({tmo, ot, resp, d} !== {1'b0, 1'b1, m_resp(a), m_read(a)}) begin errors++; $display("FAIL rnd_read%0d a=%h got=%h/%b want=%h/%b tmo=%0d ontime=%0d", i, a, d, resp, m_read(a), m_resp(a), tmo, ot); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_same_cycle();
      test_w_before_aw();
      test_burst_backpressure();
      test_collision();
      test_range();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
